pulse_height_analyzer: RTL
==========================

# pulse_height_analyzer

Consumer at the output end of the trapezoidal shaping chain. Reads the signed trapezoid stream, detects each pulse by rising threshold crossing, waits a programmable delay into the flat-top, and averages 2^n flat-top samples. Emits one pulse-height event per accepted pulse on an AXI-Stream master with backpressure. Rejects pile-up and counts rejected and dropped events for the PS-side register map.

## Interface
- AXIS_TDATA_WIDTH, 32, width of input samples and output height (matches the shaper's 2×16 output)
- TIME_WIDTH, 32, width of the sample-count timestamp
- clk  in  1  single system clock; all logic on posedge
- areset  in  1  synchronous, active-high reset
- s_axis_tdata  in  AXIS_TDATA_WIDTH  signed trapezoid sample
- s_axis_tvalid  in  1  sample qualifier; no tready, the stream is never stalled
- threshold  in  AXIS_TDATA_WIDTH  signed trigger level
- flat_delay  in  14  valid samples from crossing to first averaged sample
- avg_log2  in  3  average 2^avg_log2 samples; values >4 clamp to 4
- holdoff  in  16  minimum valid samples after sampling ends before re-arm
- m_axis_tdata  out  AXIS_TDATA_WIDTH  signed averaged pulse height
- m_axis_tuser  out  TIME_WIDTH  timestamp latched at crossing
- m_axis_tvalid  out  1  event valid
- m_axis_tready  in  1  downstream accept
- pileup_count  out  16  pulses aborted by pile-up, saturating
- drop_count  out  16  results lost to a full output register, saturating

## Operation
- Only cycles with s_axis_tvalid=1 are sample steps. All counters, the FSM and the below-threshold history advance on sample steps only.
- Free-running sample counter ts (TIME_WIDTH, wraps) increments every sample step.
- below flag: registered (sample < threshold); reset value 1.
- FSM states: IDLE, WAIT, SAMPLE, HOLDOFF.
  - IDLE: on a sample step with sample ≥ threshold and below=1 (rising crossing), do all of: latch ts, flat_delay, clamped avg_log2 and holdoff; clear the accumulator. Go to SAMPLE if flat_delay=0, else go to WAIT.
  - WAIT: count down flat_delay sample steps, then go to SAMPLE. A sample < threshold aborts: pileup_count++, go to HOLDOFF.
  - SAMPLE: add each sample into a signed accumulator of AXIS_TDATA_WIDTH+4 bits.
    - After 2^n samples, result = accumulator >>> n, truncated to AXIS_TDATA_WIDTH. Offer the result to the output register, then go to HOLDOFF.
    - A sample < threshold aborts: pileup_count++, no result, go to HOLDOFF.
  - HOLDOFF: count the latched holdoff sample steps. Return to IDLE only when the count has expired and below=1. The crossing needs a fresh rising edge, so a still-high trapezoid never retriggers.
- Output register: single entry.
  - Loaded when m_axis_tvalid=0, or when m_axis_tready=1 in the same cycle (simultaneous accept and load is a load).
  - If the register is full and not being accepted, the new result is discarded and drop_count++.
- Config inputs may change at any time; they take effect only at the next crossing.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values: FSM=IDLE, below=1, ts=0, accumulator=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, pileup_count=0, drop_count=0. Reset mid-pulse discards the in-flight pulse and any held event without counting it.
- Crossing at sample step t0: the first averaged sample is step t0+flat_delay+1.
- m_axis_tvalid rises on the clock edge after the last averaged sample is registered (1-cycle latency). It then holds, with stable tdata/tuser, until the edge where tready=1.
- Timestamp = ts value on the crossing sample.
- Abort test uses the same sample being accumulated: a sub-threshold sample is never added.
- ts wrap is not an error; tuser simply wraps.

## Structure
- Shared package: FSM state encoding (IDLE/WAIT/SAMPLE/HOLDOFF), AVG_LOG2_MAX=4, ACC_GUARD=4, COUNT_WIDTH=16.
- One natural sub-module: event_out_reg. It holds the single-entry AXIS output register with load/accept/drop logic and the saturating drop counter.

## Test plan
- Trapezoid 0→1000, 20-sample rise, 40-sample flat; threshold=100, flat_delay=25, avg_log2=2, tready=1 → one event, tdata=1000, tuser = crossing index; both counters stay 0.
- Flat-top samples 998,1000,1002,1004 with avg_log2=2 → tdata=1001; avg_log2=7 with a 16-sample flat of value 500 → clamps to 16 samples, tdata=500.
- Pulse that drops below threshold after 10 samples, flat_delay=25 → no event, pileup_count=1; next clean pulse → normal event.
- tready=0, two clean pulses → first event held with stable tdata/tuser, drop_count=1; tready=1 → first event accepted, m_axis_tvalid falls.
- s_axis_tvalid toggling 1/0 → event and timestamp identical to the gap-free run, measured in valid samples.
- areset=1 asserted mid-SAMPLE, with an event pending → next edge: tvalid=0, counters 0, FSM IDLE; next crossing detected normally.

Source files
------------

// File: rtl/pulse_height_analyzer_pkg.sv
// Shared definitions for the pulse-height analyzer: FSM encoding, sizing
// constants and small saturating/clamping helpers.
package pulse_height_analyzer_pkg;

  localparam int AVG_LOG2_MAX = 4;
  localparam int ACC_GUARD    = 4;
  localparam int COUNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_SAMPLE  = 2'd2,
    ST_HOLDOFF = 2'd3
  } pha_state_e;

  function automatic logic [2:0] clamp_avg_log2(input logic [2:0] v);
    return (v > 3'(AVG_LOG2_MAX)) ? 3'(AVG_LOG2_MAX) : v;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/event_out_reg.sv
// Single-entry AXI-Stream output register. A new result either loads (empty or
// draining this cycle) or is discarded and counted in a saturating drop counter.
module event_out_reg
  import pulse_height_analyzer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   load_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  input  logic [USER_WIDTH-1:0]  user_i,
  output logic [DATA_WIDTH-1:0]  tdata_o,
  output logic [USER_WIDTH-1:0]  tuser_o,
  output logic                   tvalid_o,
  input  logic                   tready_i,
  output logic [COUNT_WIDTH-1:0] drop_count_o
);

  logic                   valid_q, valid_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [USER_WIDTH-1:0]  user_q, user_d;
  logic [COUNT_WIDTH-1:0] drop_q, drop_d;
  logic                   can_load;

  // Accept and load in the same cycle is a load, so the slot never bubbles.
  assign can_load = !valid_q || tready_i;

  // NOTE: every output of this block gets a default first, so no latch can form.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    user_d  = user_q;
    drop_d  = drop_q;
    if (load_i && can_load) begin
      valid_d = 1'b1;
      data_d  = data_i;
      user_d  = user_i;
    end else begin
      if (tready_i) valid_d = 1'b0;
      if (load_i)   drop_d  = sat_inc(drop_q);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (areset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      user_q  <= '0;
      drop_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      user_q  <= user_d;
      drop_q  <= drop_d;
    end
  end

  assign tdata_o      = data_q;
  assign tuser_o      = user_q;
  assign tvalid_o     = valid_q;
  assign drop_count_o = drop_q;

endmodule

// File: rtl/pulse_height_analyzer.sv
// Detects rising threshold crossings on the trapezoid stream, averages 2^n
// flat-top samples after a delay, rejects pile-up and emits one AXIS event per pulse.
module pulse_height_analyzer
  import pulse_height_analyzer_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int TIME_WIDTH       = 32
) (
  input  logic                        clk,
  input  logic                        areset,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] threshold,
  input  logic [13:0]                 flat_delay,
  input  logic [2:0]                  avg_log2,
  input  logic [15:0]                 holdoff,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [TIME_WIDTH-1:0]       m_axis_tuser,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [COUNT_WIDTH-1:0]      pileup_count,
  output logic [COUNT_WIDTH-1:0]      drop_count
);

  localparam int ACC_WIDTH = AXIS_TDATA_WIDTH + ACC_GUARD;

  pha_state_e                   state_q;
  logic                         below_q;
  logic [TIME_WIDTH-1:0]        ts_q;
  logic [TIME_WIDTH-1:0]        ts_lat_q;
  logic [13:0]                  wait_q;
  logic [2:0]                   n_q;
  logic [15:0]                  holdoff_lat_q;
  logic [15:0]                  hold_q;
  logic [4:0]                   scnt_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic [COUNT_WIDTH-1:0]       pileup_q;
  logic                         offer_q;
  logic [AXIS_TDATA_WIDTH-1:0]  result_q;

  logic                         step;
  logic                         below_now;
  logic signed [ACC_WIDTH-1:0]  sample_ext;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic [AXIS_TDATA_WIDTH-1:0]  result;
  logic [4:0]                   last_idx;

  assign step       = s_axis_tvalid;
  assign below_now  = $signed(s_axis_tdata) < $signed(threshold);
  assign sample_ext = {{ACC_GUARD{s_axis_tdata[AXIS_TDATA_WIDTH-1]}}, s_axis_tdata};
  assign acc_sum    = acc_q + sample_ext;
  assign result     = AXIS_TDATA_WIDTH'(acc_sum >>> n_q);
  assign last_idx   = 5'((5'd1 << n_q) - 5'd1);

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q       <= ST_IDLE;
      below_q       <= 1'b1;
      ts_q          <= '0;
      ts_lat_q      <= '0;
      wait_q        <= '0;
      n_q           <= '0;
      holdoff_lat_q <= '0;
      hold_q        <= '0;
      scnt_q        <= '0;
      acc_q         <= '0;
      pileup_q      <= '0;
      offer_q       <= 1'b0;
      result_q      <= '0;
    end else begin
      offer_q <= 1'b0;
      if (step) begin
        ts_q    <= ts_q + 1'b1;
        below_q <= below_now;
        unique case (state_q)
          ST_IDLE: begin
            // Only a fresh rising edge triggers; config is captured here.
            if (!below_now && below_q) begin
              ts_lat_q      <= ts_q;
              wait_q        <= flat_delay;
              n_q           <= clamp_avg_log2(avg_log2);
              holdoff_lat_q <= holdoff;
              acc_q         <= '0;
              scnt_q        <= '0;
              state_q       <= (flat_delay == 14'd0) ? ST_SAMPLE : ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (below_now) begin
              pileup_q <= sat_inc(pileup_q);
              hold_q   <= holdoff_lat_q;
              state_q  <= ST_HOLDOFF;
            end else if (wait_q == 14'd1) begin
              state_q <= ST_SAMPLE;
            end else begin
              wait_q <= wait_q - 14'd1;
            end
          end
          ST_SAMPLE: begin
            // A sub-threshold sample aborts before it can reach the accumulator.
            if (below_now) begin
              pileup_q <= sat_inc(pileup_q);
              hold_q   <= holdoff_lat_q;
              state_q  <= ST_HOLDOFF;
            end else begin
              acc_q  <= acc_sum;
              scnt_q <= scnt_q + 5'd1;
              if (scnt_q == last_idx) begin
                result_q <= result;
                offer_q  <= 1'b1;
                hold_q   <= holdoff_lat_q;
                state_q  <= ST_HOLDOFF;
              end
            end
          end
          ST_HOLDOFF: begin
            if (hold_q != 16'd0) begin
              hold_q <= hold_q - 16'd1;
            end else if (below_q) begin
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign pileup_count = pileup_q;

  event_out_reg #(
    .DATA_WIDTH (AXIS_TDATA_WIDTH),
    .USER_WIDTH (TIME_WIDTH)
  ) u_event_out_reg (
    .clk          (clk),
    .areset       (areset),
    .load_i       (offer_q),
    .data_i       (result_q),
    .user_i       (ts_lat_q),
    .tdata_o      (m_axis_tdata),
    .tuser_o      (m_axis_tuser),
    .tvalid_o     (m_axis_tvalid),
    .tready_i     (m_axis_tready),
    .drop_count_o (drop_count)
  );

endmodule
